// File: rtl/tx_skp_insert_pkg.sv
// Shared symbol codes, FSM encoding and framing helpers for the TX SKP inserter.
package tx_skp_insert_pkg;

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_EDB = 8'hFE;

    typedef enum logic {
        S_PASS = 1'b0,
        S_SKP  = 1'b1
    } state_t;

    function automatic logic is_pkt_start(input logic k, input logic [7:0] d);
        return k && ((d == K_STP) || (d == K_SDP));
    endfunction

    function automatic logic is_pkt_end(input logic k, input logic [7:0] d);
        return k && ((d == K_END) || (d == K_EDB));
    endfunction

endpackage

// File: rtl/skp_interval_timer.sv
// SKP interval timer: symbol counter, pending request and late flag.
// Latency: pending is combinational on force/threshold; late is a registered pulse.
// Backpressure: none; clr holds the counter at zero while a set is in progress.
module skp_interval_timer
    import tx_skp_insert_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_MAX      = 1538,
    localparam int CW          = $clog2(SKP_MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic skp_disable,
    input  logic force_req,
    output logic pending,
    output logic late
);

    localparam logic [CW-1:0] INTERVAL = CW'(SKP_INTERVAL);
    localparam logic [CW-1:0] MAX      = CW'(SKP_MAX);
    localparam logic [CW-1:0] MAX_M1   = CW'(SKP_MAX - 1);

    logic [CW-1:0] sym_cnt_q, sym_cnt_d;
    logic          pending_q, pending_d;
    logic          late_q, late_d;

    always_comb begin
        pending   = ~skp_disable & (pending_q | force_req | (sym_cnt_q >= INTERVAL));
        sym_cnt_d = sym_cnt_q;
        pending_d = pending;
        late_d    = 1'b0;
        if (skp_disable || clr) begin
            sym_cnt_d = '0;
            pending_d = 1'b0;
        end else begin
            if (sym_cnt_q != MAX) begin
                sym_cnt_d = sym_cnt_q + CW'(1);
            end
            // Only the step onto MAX fires; a saturated counter stays quiet.
            late_d = pending && (sym_cnt_q == MAX_M1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sym_cnt_q <= '0;
            pending_q <= 1'b0;
            late_q    <= 1'b0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            pending_q <= pending_d;
            late_q    <= late_d;
        end
    end

    assign late = late_q;

endmodule

// File: rtl/tx_skp_insert.sv
// TX clock-tolerance compensation: inserts COM + SKP_LEN x SKP between packets.
// Latency: accepted symbol appears on data_out one clock later.
// Backpressure: in_ready low on the COM-decision cycle and through the SKP symbols.
module tx_skp_insert
    import tx_skp_insert_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_MAX      = 1538,
    parameter int SKP_LEN      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_skp_disable,
    input  logic       tx_skp_force,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_kcntl,
    output logic       in_ready,
    output logic [7:0] data_out,
    output logic       kcntl_out,
    output logic       skp_inserted,
    output logic       skp_late,
    output logic       in_pkt
);

    localparam logic [2:0] LEN = 3'(SKP_LEN);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       kcntl_q, kcntl_d;
    logic       skp_ins_q, skp_ins_d;
    logic       in_pkt_q, in_pkt_d;

    logic pending, late, start_skp, accept, timer_clr, force_ok;

    assign force_ok  = tx_skp_force & (state_q == S_PASS);
    assign start_skp = pending & ~in_pkt_q & ~tx_skp_disable & (state_q == S_PASS);
    assign in_ready  = (state_q == S_PASS) & ~start_skp;
    assign accept    = in_valid & in_ready;
    // Counting resumes only after the last SKP, so the period covers the whole set.
    assign timer_clr = start_skp | (state_q == S_SKP);

    skp_interval_timer #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_MAX      (SKP_MAX)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (timer_clr),
        .skp_disable (tx_skp_disable),
        .force_req   (force_ok),
        .pending     (pending),
        .late        (late)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = 8'h00;
        kcntl_d   = 1'b0;
        skp_ins_d = 1'b0;
        in_pkt_d  = in_pkt_q;

        if (accept) begin
            if (is_pkt_start(in_kcntl, in_data)) begin
                in_pkt_d = 1'b1;
            end else if (is_pkt_end(in_kcntl, in_data)) begin
                in_pkt_d = 1'b0;
            end
        end

        case (state_q)
            S_PASS: begin
                if (start_skp) begin
                    data_d    = K_COM;
                    kcntl_d   = 1'b1;
                    skp_ins_d = 1'b1;
                    state_d   = S_SKP;
                    cnt_d     = 3'd1;
                end else if (accept) begin
                    data_d  = in_data;
                    kcntl_d = in_kcntl;
                end
            end
            S_SKP: begin
                data_d  = K_SKP;
                kcntl_d = 1'b1;
                if (cnt_q == LEN) begin
                    state_d = S_PASS;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = S_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_PASS;
            cnt_q     <= 3'd0;
            data_q    <= 8'h00;
            kcntl_q   <= 1'b0;
            skp_ins_q <= 1'b0;
            in_pkt_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            kcntl_q   <= kcntl_d;
            skp_ins_q <= skp_ins_d;
            in_pkt_q  <= in_pkt_d;
        end
    end

    assign data_out     = data_q;
    assign kcntl_out    = kcntl_q;
    assign skp_inserted = skp_ins_q;
    assign skp_late     = late;
    assign in_pkt       = in_pkt_q;

endmodule

// File: tb/tb_tx_skp_insert.sv
// Directed bench for tx_skp_insert: idle, streaming, long packet, force, disable, reset abort.
module tb_tx_skp_insert;
    import tx_skp_insert_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_skp_disable = 1'b0;
    logic       tx_skp_force = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_kcntl = 1'b0;
    logic       in_ready;
    logic [7:0] data_out;
    logic       kcntl_out;
    logic       skp_inserted;
    logic       skp_late;
    logic       in_pkt;

    tx_skp_insert dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_skp_disable (tx_skp_disable),
        .tx_skp_force   (tx_skp_force),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_kcntl       (in_kcntl),
        .in_ready       (in_ready),
        .data_out       (data_out),
        .kcntl_out      (kcntl_out),
        .skp_inserted   (skp_inserted),
        .skp_late       (skp_late),
        .in_pkt         (in_pkt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // cycle N = output registered on the N-th rising edge after reset release
    int         cyc;
    int         start_cyc;
    int         com_cyc[$];
    logic [8:0] out_log[$];
    logic [8:0] tx_q[$];
    logic [8:0] exp_q[$];
    int         skp_cnt, late_cnt, late_cyc, rdy_low, out_err, out_cnt, ins_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic int sym9(input logic k, input logic [7:0] d);
        return int'({k, d});
    endfunction

    function automatic int osym(input int c);
        if (c < 1 || c > out_log.size()) return -1;
        return int'(out_log[c-1]);
    endfunction

    function automatic int get_com(input int i);
        if (i < com_cyc.size()) return com_cyc[i];
        return -1;
    endfunction

    task automatic clear_stats();
        cyc = 0; start_cyc = 0;
        com_cyc.delete(); out_log.delete(); tx_q.delete(); exp_q.delete();
        skp_cnt = 0; late_cnt = 0; late_cyc = -1; rdy_low = 0;
        out_err = 0; out_cnt = 0; ins_err = 0;
    endtask

    task automatic tick();
        logic rdy;
        if (tx_q.size() > 0 && cyc + 1 >= start_cyc) begin
            in_valid = 1'b1;
            {in_kcntl, in_data} = tx_q[0];
        end else begin
            in_valid = 1'b0; in_kcntl = 1'b0; in_data = 8'h00;
        end
        #1;
        rdy = in_ready;
        if (!rdy) rdy_low++;
        @(posedge clk);
        if (in_valid && rdy) void'(tx_q.pop_front());
        @(negedge clk);
        cyc++;
        out_log.push_back({kcntl_out, data_out});
        if (skp_late) begin
            late_cnt++;
            late_cyc = cyc;
        end
        if (kcntl_out && data_out == K_COM) begin
            com_cyc.push_back(cyc);
            if (!skp_inserted) ins_err++;
        end else begin
            if (skp_inserted) ins_err++;
            if (kcntl_out && data_out == K_SKP) skp_cnt++;
            else if (kcntl_out || data_out != 8'h00) begin
                if (exp_q.size() == 0 || exp_q[0] != {kcntl_out, data_out}) out_err++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                out_cnt++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tx_skp_disable = 1'b0; tx_skp_force = 1'b0;
        in_valid = 1'b0; in_kcntl = 1'b0; in_data = 8'h00;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic push_pkt(input int len);
        logic [8:0] s;
        for (int i = 0; i < len; i++) begin
            if (i == 0) s = {1'b1, K_STP};
            else if (i == len - 1) s = {1'b1, K_END};
            else s = {1'b0, 8'((i % 255) + 1)};
            tx_q.push_back(s);
            exp_q.push_back(s);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        // idle-only schedule, then reset during the second SKP
        do_reset();
        #1;
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_kcntl_out", int'(kcntl_out), 0);
        chk("rst_skp_inserted", int'(skp_inserted), 0);
        chk("rst_skp_late", int'(skp_late), 0);
        chk("rst_in_pkt", int'(in_pkt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        while (cyc < 2367) tick();
        chk("idle_first_com", get_com(0), 1181);
        chk("idle_skp1", osym(1182), sym9(1'b1, K_SKP));
        chk("idle_skp3", osym(1184), sym9(1'b1, K_SKP));
        chk("idle_after_set", osym(1185), 0);
        chk("idle_second_com", get_com(1), 2365);
        chk("idle_no_late", late_cnt, 0);
        chk("idle_second_skp2", osym(2367), sym9(1'b1, K_SKP));
        rst_n = 1'b0;
        tick();
        chk("abort_data_out", int'(data_out), 0);
        chk("abort_kcntl_out", int'(kcntl_out), 0);
        rst_n = 1'b1;
        clear_stats();
        while (cyc < 1190) tick();
        chk("abort_next_com", get_com(0), 1181);

        // forced insert, with a second force during the set being ignored
        do_reset();
        repeat (10) tick();
        tx_skp_force = 1'b1;
        tick();
        chk("force_com_data", sym9(kcntl_out, data_out), sym9(1'b1, K_COM));
        chk("force_skp_inserted", int'(skp_inserted), 1);
        tick();
        tx_skp_force = 1'b0;
        while (cyc < 1200) tick();
        chk("force_next_com", get_com(1), 1195);
        chk("force_no_extra", get_com(2), -1);
        chk("force_ins_pulse", ins_err, 0);

        // disabled for 5000 cycles, then re-enabled
        do_reset();
        tx_skp_disable = 1'b1;
        repeat (5000) tick();
        chk("dis_no_com", com_cyc.size(), 0);
        chk("dis_no_skp", skp_cnt, 0);
        chk("dis_ready_low", rdy_low, 0);
        chk("dis_no_late", late_cnt, 0);
        tx_skp_disable = 1'b0;
        repeat (1190) tick();
        chk("dis_release_com", get_com(0), 6181);

        // back-to-back 16-symbol packets across the interval
        do_reset();
        start_cyc = 1;
        for (int p = 0; p < 80; p++) push_pkt(16);
        repeat (1300) tick();
        chk("stream_end_before_com", osym(1184), sym9(1'b1, K_END));
        chk("stream_com", get_com(0), 1185);
        chk("stream_ready_low", rdy_low, 4);
        chk("stream_stp_after", osym(1189), sym9(1'b1, K_STP));
        chk("stream_order_err", out_err, 0);
        chk("stream_count", out_cnt, 1280);
        chk("stream_drained", tx_q.size(), 0);

        // one long packet holds the insert past SKP_MAX
        do_reset();
        start_cyc = 1100;
        push_pkt(500);
        repeat (1620) tick();
        chk("long_late_count", late_cnt, 1);
        chk("long_late_cycle", late_cyc, 1538);
        chk("long_end", osym(1599), sym9(1'b1, K_END));
        chk("long_com", get_com(0), 1600);
        chk("long_order_err", out_err, 0);
        chk("long_count", out_cnt, 500);
        chk("long_in_pkt_end", int'(in_pkt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
